// File: rtl/fx_match_sched.sv
// Shared fixed-point format matcher: round-robin arbitration over NUM_REQ requesters,
// quantize (floor or round-half-up) then saturate in a stallable PIPE_LAT-deep pipeline.
module fx_match_sched #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_W    = 2,
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 10,
    parameter int OUT_FRAC = 4,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      i_valid,
    input  logic [NUM_REQ*IN_W-1:0] i_data,
    input  logic [NUM_REQ-1:0]      i_rnd,
    output logic [NUM_REQ-1:0]      i_ready,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [OUT_W-1:0]        o_data,
    output logic [TAG_W-1:0]        o_tag,
    output logic                    o_ovf,
    input  logic                    i_cnt_clr,
    output logic [CNT_W-1:0]        o_ovf_cnt
);
    localparam int S       = IN_FRAC - OUT_FRAC;
    localparam int QW      = IN_W + 1 - S;
    localparam int LAST    = PIPE_LAT - 1;
    localparam int SAT_IDX = (PIPE_LAT >= 2) ? 1 : 0;
    localparam logic [IN_W:0]          RND_HALF = (IN_W+1)'(1) << (S - 1);
    localparam logic signed [QW-1:0]   Q_MAX    = QW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [QW-1:0]   Q_MIN    = ~Q_MAX;
    localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};

    // Taking the upper bits of the sign-extended sum is the arithmetic shift by S.
    function automatic logic [QW-1:0] quantize(input logic [IN_W-1:0] din, input logic rnd);
        logic [IN_W:0] ext;
        ext = {din[IN_W-1], din} + (rnd ? RND_HALF : {(IN_W+1){1'b0}});
        return ext[IN_W:S];
    endfunction

    function automatic logic sat_ovf(input logic [QW-1:0] q);
        return ($signed(q) > Q_MAX) || ($signed(q) < Q_MIN);
    endfunction

    function automatic logic [QW-1:0] sat_val(input logic [QW-1:0] q);
        if (sat_ovf(q)) begin
            return q[QW-1] ? Q_MIN : Q_MAX;
        end else begin
            return q;
        end
    endfunction

    logic               adv_s;
    logic               acc_s;
    logic               found_s;
    logic [TAG_W-1:0]   idx_s;
    logic [TAG_W-1:0]   gnt_idx_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [QW-1:0]      q_s;
    logic [TAG_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               v_q [PIPE_LAT];
    logic               v_d [PIPE_LAT];
    logic [QW-1:0]      w_q [PIPE_LAT];
    logic [QW-1:0]      w_d [PIPE_LAT];
    logic [TAG_W-1:0]   t_q [PIPE_LAT];
    logic [TAG_W-1:0]   t_d [PIPE_LAT];
    logic               f_q [PIPE_LAT];
    logic               f_d [PIPE_LAT];

    // Round-robin search starting after the last granted requester, plus input quantize.
    always_comb begin
        found_s   = 1'b0;
        idx_s     = '0;
        gnt_idx_s = '0;
        gnt_s     = '0;
        adv_s     = ~v_q[LAST] | o_ready;
        for (int j = 1; j <= NUM_REQ; j++) begin
            idx_s = TAG_W'((int'(last_q) + j) % NUM_REQ);
            if (!found_s && i_valid[idx_s]) begin
                found_s   = 1'b1;
                gnt_idx_s = idx_s;
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s && adv_s && rst_n) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
        acc_s = |gnt_s;
        q_s   = quantize(i_data[gnt_idx_s*IN_W +: IN_W], i_rnd[gnt_idx_s]);
    end

    // Pipeline advance, arbitration pointer update and overflow counter next-state.
    always_comb begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            v_d[i] = v_q[i];
            w_d[i] = w_q[i];
            t_d[i] = t_q[i];
            f_d[i] = f_q[i];
        end
        if (adv_s) begin
            v_d[0] = acc_s;
            t_d[0] = gnt_idx_s;
            w_d[0] = (SAT_IDX == 0) ? sat_val(q_s) : q_s;
            f_d[0] = (SAT_IDX == 0) ? sat_ovf(q_s) : 1'b0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                v_d[i] = v_q[i-1];
                t_d[i] = t_q[i-1];
                w_d[i] = (i == SAT_IDX) ? sat_val(w_q[i-1]) : w_q[i-1];
                f_d[i] = (i == SAT_IDX) ? sat_ovf(w_q[i-1]) : f_q[i-1];
            end
        end else begin
            v_d[0] = v_q[0];
        end
        if (acc_s) begin
            last_d = gnt_idx_s;
        end else begin
            last_d = last_q;
        end
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (v_q[LAST] && o_ready && f_q[LAST] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                v_q[i] <= 1'b0;
                w_q[i] <= '0;
                t_q[i] <= '0;
                f_q[i] <= 1'b0;
            end
            last_q <= TAG_W'(NUM_REQ - 1);
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                v_q[i] <= v_d[i];
                w_q[i] <= w_d[i];
                t_q[i] <= t_d[i];
                f_q[i] <= f_d[i];
            end
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign i_ready   = gnt_s;
    assign o_valid   = v_q[LAST];
    assign o_data    = w_q[LAST][OUT_W-1:0];
    assign o_tag     = t_q[LAST];
    assign o_ovf     = f_q[LAST];
    assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_fx_match_sched.sv
// Scoreboard bench for fx_match_sched: directed words push expected outputs, a forked
// monitor pops and compares on every output transfer. A CNT_W=2 copy checks counter hold.
module tb_fx_match_sched;
    localparam int NR = 4;
    localparam int IW = 16;
    localparam int OW = 10;
    localparam int TW = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [OW-1:0] data;
        logic          ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    i_valid, i_rnd, i_ready, i_ready2;
    logic [NR*IW-1:0] i_data;
    logic             o_valid, o_ready, o_ovf, i_cnt_clr, o_valid2, o_ovf2;
    logic [OW-1:0]    o_data, o_data2;
    logic [TW-1:0]    o_tag, o_tag2;
    logic [15:0]      o_ovf_cnt;
    logic [1:0]       o_ovf_cnt2;

    exp_t sb[$];
    int   grants[$];
    int   nxt[NR];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fx_match_sched dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_rnd(i_rnd),
        .i_ready(i_ready), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_tag(o_tag), .o_ovf(o_ovf), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt)
    );

    fx_match_sched #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_rnd(i_rnd),
        .i_ready(i_ready2), .o_valid(o_valid2), .o_ready(o_ready), .o_data(o_data2),
        .o_tag(o_tag2), .o_ovf(o_ovf2), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && o_valid && o_ready) begin
                chk("out_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("o_data", 32'(o_data), 32'(e.data));
                    chk("o_tag", 32'(o_tag), 32'(e.tag));
                    chk("o_ovf", 32'(o_ovf), 32'(e.ovf));
                    chk("o_valid2", 32'(o_valid2), 32'd1);
                    chk("o_data2", 32'(o_data2), 32'(e.data));
                    chk("o_tag2", 32'(o_tag2), 32'(e.tag));
                    chk("o_ovf2", 32'(o_ovf2), 32'(e.ovf));
                end
            end
        end
    endtask

    task automatic send(input int r, input logic [15:0] d, input logic rnd,
                        input logic [OW-1:0] ed, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        i_valid[2'(r)]     = 1'b1;
        i_rnd[2'(r)]       = rnd;
        i_data[r*IW +: IW] = d;
        #1;
        while (!i_ready[2'(r)] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_granted", 32'(i_ready[2'(r)]), 32'd1);
        if (i_ready[2'(r)]) begin
            sb.push_back({TW'(r), ed, eo});
        end
        @(posedge clk);
        #1;
        i_valid[2'(r)] = 1'b0;
    endtask

    // All requesters valid every cycle; requester r's n-th word is 0x100*(r+1)+0x10*n, truncated.
    task automatic run_all(input int cycles, input logic rdy, input bit stall);
        logic [OW-1:0] snap_d;
        logic [TW-1:0] snap_t;
        int g;
        snap_d = '0;
        snap_t = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            o_ready = rdy;
            for (int r = 0; r < NR; r++) begin
                i_valid[2'(r)]     = 1'b1;
                i_rnd[2'(r)]       = 1'b0;
                i_data[r*IW +: IW] = 16'(16'h0100 * (r + 1) + 16'h0010 * nxt[r]);
            end
            #1;
            chk("ready_onehot", 32'($onehot0(i_ready)), 32'd1);
            if (stall) begin
                chk("stall_ready", 32'(i_ready), 32'd0);
                chk("stall_valid", 32'(o_valid), 32'd1);
                if (c == 0) begin
                    snap_d = o_data;
                    snap_t = o_tag;
                end else begin
                    chk("stall_data", 32'(o_data), 32'(snap_d));
                    chk("stall_tag", 32'(o_tag), 32'(snap_t));
                end
            end
            g = -1;
            for (int r = 0; r < NR; r++) begin
                if (i_ready[2'(r)]) g = r;
            end
            if (g >= 0) begin
                sb.push_back({TW'(g), OW'(16 * (g + 1) + nxt[g]), 1'b0});
                grants.push_back(g);
                nxt[g]++;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = '0;
        o_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_valid   = '1;
        i_rnd     = '0;
        i_data    = '0;
        o_ready   = 1'b1;
        i_cnt_clr = 1'b0;
        for (int r = 0; r < NR; r++) nxt[r] = 0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_tag", 32'(o_tag), 32'd0);
        chk("rst_o_ovf", 32'(o_ovf), 32'd0);
        chk("rst_cnt", 32'(o_ovf_cnt), 32'd0);
        chk("rst_ready", 32'(i_ready), 32'd0);
        i_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 16'h0018, 1'b1, 10'h002, 1'b0);
        chk("lat_early", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_on", 32'(o_valid), 32'd1);

        send(1, 16'h0008, 1'b1, 10'h001, 1'b0);
        send(2, 16'h0008, 1'b0, 10'h000, 1'b0);
        send(3, 16'h0007, 1'b1, 10'h000, 1'b0);
        send(0, 16'hFFE8, 1'b1, 10'h3FF, 1'b0);
        send(1, 16'hFFE8, 1'b0, 10'h3FE, 1'b0);
        drain();
        chk("cnt_no_ovf", 32'(o_ovf_cnt), 32'd0);

        send(2, 16'h7FFF, 1'b1, 10'h1FF, 1'b1);
        send(3, 16'h8000, 1'b0, 10'h200, 1'b1);
        drain();
        chk("cnt_two", 32'(o_ovf_cnt), 32'd2);
        chk("cnt2_two", 32'(o_ovf_cnt2), 32'd2);

        send(0, 16'h7FFF, 1'b1, 10'h1FF, 1'b1);
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(o_ovf_cnt), 32'd0);
        chk("cnt2_clr_wins", 32'(o_ovf_cnt2), 32'd0);
        drain();

        for (int k = 0; k < 5; k++) send(k % NR, 16'h7FFF, 1'b1, 10'h1FF, 1'b1);
        drain();
        chk("cnt_five", 32'(o_ovf_cnt), 32'd5);
        chk("cnt2_hold", 32'(o_ovf_cnt2), 32'd3);

        // Fresh reset so the rotation starts at requester 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        grants.delete();
        run_all(8, 1'b1, 1'b0);
        idle();
        chk("rr_count", 32'(grants.size()), 32'd8);
        for (int k = 0; k < grants.size(); k++) chk("rr_order", 32'(grants[k]), 32'(k % NR));
        drain();

        run_all(2, 1'b0, 1'b0);
        run_all(5, 1'b0, 1'b1);
        grants.delete();
        run_all(4, 1'b1, 1'b0);
        idle();
        chk("resume_grants", 32'(grants.size()), 32'd4);
        drain();

        run_all(2, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_ready", 32'(i_ready), 32'd0);
        chk("rst_mid_ready2", 32'(i_ready2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_cnt", 32'(o_ovf_cnt), 32'd0);
        chk("rst_mid_data", 32'(o_data), 32'd0);
        chk("rst_mid_first", 32'(i_ready), 32'd1);
        i_valid = '0;
        o_ready = 1'b1;
        grants.delete();
        run_all(4, 1'b1, 1'b0);
        idle();
        chk("post_rst_grants", 32'(grants.size()), 32'd4);
        if (grants.size() > 0) chk("post_rst_first", 32'(grants[0]), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fx_match_sched.md
Name: fx_match_sched

Overview:
- Shares one fixed-point format-match datapath (quantize, then saturate) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Stallable PIPE_LAT-deep pipeline; one output stream tagged with the requester index.
- Sits between several DSP producers and a common downstream consumer; replaces per-producer format matchers where throughput allows.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 2, tag width, equal to ceil(log2(NUM_REQ)).
- IN_W, 16, input word width, signed two's complement.
- IN_FRAC, 8, input fractional bits.
- OUT_W, 10, output word width, signed.
- OUT_FRAC, 4, output fractional bits; IN_FRAC-OUT_FRAC >= 1.
- PIPE_LAT, 2, datapath pipeline depth in cycles (>= 1).
- CNT_W, 16, overflow event counter width.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_valid  in  NUM_REQ  per-requester data valid
- i_data  in  NUM_REQ*IN_W  packed request words; requester r occupies bits [r*IN_W +: IN_W]
- i_rnd  in  NUM_REQ  per-requester quantize mode: 0 = truncate (floor), 1 = round half up
- i_ready  out  NUM_REQ  one-hot grant; a word transfers when i_valid[r] & i_ready[r]
- o_valid  out  1  output valid
- o_ready  in  1  downstream ready
- o_data  out  OUT_W  converted word
- o_tag  out  TAG_W  index of the requester that produced o_data
- o_ovf  out  1  this word was saturated
- i_cnt_clr  in  1  clear overflow counter
- o_ovf_cnt  out  CNT_W  saturating count of saturated words delivered

Behaviour:
- Reset (rst_n=0 at an edge):
  - all pipeline valid bits cleared; o_valid=0.
  - o_data, o_tag, o_ovf = 0; o_ovf_cnt = 0.
  - RR pointer last = NUM_REQ-1, so requester 0 has first priority.
  - i_ready = 0 while rst_n = 0.
  - Reset mid-operation drops all in-flight words; no output is produced for them.
- Advance enable: adv = ~o_valid | o_ready. When adv=0 every stage holds its value, including o_data and o_tag.
- Arbitration is combinational. When adv=1, grant the first r with i_valid[r]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - i_ready is one-hot or zero. i_ready[r] may be asserted only when i_valid[r]=1.
  - On a transfer, last <= r. If nothing is granted, last is unchanged.
- Throughput: one word per cycle when o_ready is held high.
- Latency: a word accepted at edge k shows o_valid=1 after edge k+PIPE_LAT-1, i.e. on the cycle following the PIPE_LAT-th edge counting from acceptance. Each stall cycle adds one.
- The tag, i_rnd bit and data are captured together and travel in lockstep.
- Arithmetic, with S = IN_FRAC-OUT_FRAC:
  - Sign-extend the input to IN_W+1 bits.
  - If rnd=1, add 2^(S-1).
  - Arithmetic shift right by S, giving q of width IN_W+1-S.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. ovf=1 when q is outside that range.
  - Quantize lands in stage 1. Saturate lands in stage min(2, PIPE_LAT). Remaining stages are pure delay.
- Counter:
  - o_ovf_cnt increments by 1 on each output transfer (o_valid & o_ready) with o_ovf=1.
  - It holds at 2^CNT_W-1 and never wraps.
  - i_cnt_clr=1 forces 0 and wins over a simultaneous increment.
- Requester-side rules:
  - A requester holds i_data and i_rnd stable while i_valid=1 and it is not granted.
  - The block never drops or duplicates an accepted word.
  - Words from the same requester leave in acceptance order.
- Boundary conditions:
  - Only one requester valid: it is granted every adv cycle.
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - A requester dropping i_valid without being granted is legal; nothing transfers.
  - o_ready low with a full pipeline: no grants.
  - o_ready returning high: grant occurs in the same cycle.

Test Plan:
- Reset then single word: req0, data 0x0018, rnd=1, o_ready=1 -> o_valid one cycle after the 2nd edge from acceptance; o_data=0x002, o_tag=0, o_ovf=0.
- Rounding vs truncate:
  - 0x0008, rnd=1 -> 0x001. 0x0008, rnd=0 -> 0x000.
  - 0x0007, rnd=1 -> 0x000.
  - 0xFFE8 (-24), rnd=1 -> 0x3FF (-1). 0xFFE8, rnd=0 -> 0x3FE (-2).
- Saturation and counter:
  - 0x7FFF, rnd=1 -> 0x1FF, o_ovf=1. 0x8000, rnd=0 -> 0x200, o_ovf=1. o_ovf_cnt reaches 2.
  - Pulse i_cnt_clr in the same cycle as a third ovf transfer -> o_ovf_cnt=0.
  - With CNT_W forced to 2, five ovf words -> o_ovf_cnt holds 3.
- Round-robin fairness:
  - All 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
  - Output tags in the same order; each requester's data intact.
- Backpressure:
  - o_ready=0 for 5 cycles with a full pipeline -> i_ready=0, o_data/o_tag stable.
  - On o_ready=1 -> one word per cycle resumes; nothing lost or duplicated (scoreboard per tag).
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 words in flight -> o_valid=0, o_ovf_cnt=0, no stale words appear; next grant goes to requester 0.
